simple_uart_tx_feeder: RTL and testbench

//  Upstream stage of simple_uart. Buffers bytes from a valid/ready producer in a FIFO.

---
 rtl/simple_uart_tx_feeder_pkg.sv | 19 +
 rtl/simple_uart_fifo.sv | 66 ++++++
 rtl/simple_uart_tx_feeder.sv | 101 ++++++++++
 tb/tb_simple_uart_tx_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_tx_feeder_pkg.sv
// Shared definitions for the simple_uart transmit feeder: frame geometry,
// FSM state encoding and a helper that derives the frame spacing in clocks.
package simple_uart_tx_feeder_pkg;

  // One UART frame: start bit, eight data bits, stop bit.
  localparam int UART_FRAME_BITS = 10;

  // Feeder pacing states; encodings are shared with simple_uart and the RX side.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } feeder_state_t;

  // Clocks between consecutive writes into simple_uart (one frame plus guard).
  function automatic int frame_cycles(input int sys_freq, input int baud, input int guard);
    return UART_FRAME_BITS * (sys_freq / baud) + guard;
  endfunction

endpackage

// File: rtl/simple_uart_fifo.sv
// Synchronous show-ahead FIFO used by the UART transmit feeder.
// Level is a dedicated counter (0..DEPTH) so full and empty are never ambiguous.
// Pushes while full and pops while empty are ignored; flush clears everything
// at the next edge and drops any push in that cycle.
module simple_uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push & (level != FULL_LEVEL) & ~flush;
  assign do_pop  = pop & (level != '0);
  assign dout    = mem[rd_ptr];

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy and flush empties the queue.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/simple_uart_tx_feeder.sv
// Upstream stage of simple_uart. Buffers bytes from a valid/ready producer
// and paces them onto tx_value/tx_value_write. simple_uart has no ready
// output, so writes are spaced by one full frame time plus a guard interval.
module simple_uart_tx_feeder
  import simple_uart_tx_feeder_pkg::*;
#(
  parameter int SYSTEM_FREQ     = 50_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int GUARD_CYCLES    = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clock,
  input  logic                      arst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [7:0]                tx_value,
  output logic                      tx_value_write,
  output logic [FIFO_DEPTH_LOG2:0]  fifo_level,
  output logic                      busy
);

  localparam int FRAME_CYCLES = frame_cycles(SYSTEM_FREQ, BAUD_RATE, GUARD_CYCLES);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL =
    (FIFO_DEPTH_LOG2+1)'(1 << FIFO_DEPTH_LOG2);

  feeder_state_t    state;
  logic [CNT_W-1:0] frame_count;
  logic [7:0]       fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             issue;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LEVEL);

  // Ready depends only on stored level and flush, never on in_valid.
  assign in_ready = ~fifo_full & ~flush;
  assign push     = in_valid & in_ready;

  // A byte leaves the FIFO when idle, or exactly when the previous frame's countdown expires.
  assign issue = ~fifo_empty & ((state == ST_IDLE) | (frame_count == '0));

  assign busy = ~fifo_empty | (state == ST_WAIT);

  simple_uart_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .arst  (arst),
    .flush (flush),
    .push  (push),
    .din   (in_data),
    .pop   (issue),
    .dout  (fifo_head),
    .level (fifo_level)
  );

  // Pacing FSM: registers the issued byte, pulses the write strobe and times the frame.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      state          <= ST_IDLE;
      frame_count    <= '0;
      tx_value       <= '0;
      tx_value_write <= 1'b0;
    end else begin
      tx_value_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            tx_value       <= fifo_head;
            tx_value_write <= 1'b1;
            frame_count    <= FRAME_LOAD;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (issue) begin
            tx_value       <= fifo_head;
            tx_value_write <= 1'b1;
            frame_count    <= FRAME_LOAD;
          end else if (frame_count == '0) begin
            state <= ST_IDLE;
          end else begin
            frame_count <= frame_count - CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_uart_tx_feeder.sv
// Directed self-checking bench for simple_uart_tx_feeder with a 100-cycle frame
// (1 MHz clock, 100 kbaud, no guard) and a 16-entry FIFO.
module tb_simple_uart_tx_feeder;

  logic       clock;
  logic       arst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] tx_value;
  logic       tx_value_write;
  logic [4:0] fifo_level;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         pulse_cyc[$];
  logic [7:0] pulse_val[$];
  logic [7:0] exp_q[$];

  int max_level;
  int full_seen;
  int last_accept_cyc;
  int accepted;
  int mark_cyc;
  int drop_cyc;

  simple_uart_tx_feeder #(
    .SYSTEM_FREQ     (1_000_000),
    .BAUD_RATE       (100_000),
    .GUARD_CYCLES    (0),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clock          (clock),
    .arst           (arst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .tx_value       (tx_value),
    .tx_value_write (tx_value_write),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to time pulses and waits.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every write strobe mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (tx_value_write === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(tx_value);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer incrementing bytes until n_bytes are accepted or max_cycles edges pass.
  task automatic applyStimulus(input int n_bytes, input int max_cycles, input logic [7:0] base);
    int k;
    int acc;
    logic ready_before;
    k = 0;
    acc = 0;
    while (acc < n_bytes && k < max_cycles) begin
      in_valid = 1'b1;
      in_data = base + 8'(acc);
      ready_before = in_ready;
      tick();
      k++;
      if (ready_before) begin
        exp_q.push_back(in_data);
        acc++;
        last_accept_cyc = cyc;
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (!in_ready && fifo_level == 5'd16) full_seen = 1;
    end
    in_valid = 1'b0;
    accepted = acc;
  endtask

  task automatic waitPulses(input int n, input int bound);
    int k;
    k = 0;
    while (pulse_val.size() < n && k < bound) begin
      tick();
      k++;
    end
    checkOutput("pulses_seen", 32'(pulse_val.size() >= n), 32'd1);
  endtask

  task automatic waitIdle(output int when);
    int k;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
    when = cyc;
  endtask

  task automatic clearLog();
    pulse_cyc.delete();
    pulse_val.delete();
    exp_q.delete();
    max_level = 0;
    full_seen = 0;
    last_accept_cyc = 0;
    accepted = 0;
  endtask

  initial begin
    arst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    flush = 1'b0;
    clearLog();

    // Reset state
    #2 arst = 1'b1;
    #1;
    checkOutput("rst_tx_value", 32'(tx_value), 32'h0);
    checkOutput("rst_write", 32'(tx_value_write), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // 1: single byte latency and busy duration
    $display("[TB] single byte latency");
    clearLog();
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    mark_cyc = cyc;
    checkOutput("t1_level_after_push", 32'(fifo_level), 32'd1);
    checkOutput("t1_no_write_yet", 32'(tx_value_write), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_write", 32'(tx_value_write), 32'd1);
    checkOutput("t1_tx_value", 32'(tx_value), 32'hA5);
    checkOutput("t1_level_after_pop", 32'(fifo_level), 32'd0);
    tick();
    checkOutput("t1_write_single", 32'(tx_value_write), 32'd0);
    waitIdle(drop_cyc);
    checkOutput("t1_busy_cycles", 32'(drop_cyc - mark_cyc), 32'd101);

    // 2: three bytes back to back
    $display("[TB] three byte spacing");
    clearLog();
    applyStimulus(3, 50, 8'h01);
    checkOutput("t2_accepted", 32'(accepted), 32'd3);
    checkOutput("t2_level_2", 32'(fifo_level), 32'd2);
    waitPulses(2, 400);
    checkOutput("t2_level_1", 32'(fifo_level), 32'd1);
    waitPulses(3, 400);
    checkOutput("t2_level_0", 32'(fifo_level), 32'd0);
    checkOutput("t2_val0", 32'(pulse_val[0]), 32'h01);
    checkOutput("t2_val1", 32'(pulse_val[1]), 32'h02);
    checkOutput("t2_val2", 32'(pulse_val[2]), 32'h03);
    checkOutput("t2_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd100);
    checkOutput("t2_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd100);
    waitIdle(drop_cyc);

    // 3: overfill with 18 bytes
    $display("[TB] overfill with 18 bytes");
    clearLog();
    applyStimulus(18, 2000, 8'h40);
    checkOutput("t3_accepted", 32'(accepted), 32'd18);
    checkOutput("t3_full_seen", 32'(full_seen), 32'd1);
    checkOutput("t3_max_level", 32'(max_level), 32'd16);
    checkOutput("t3_last_accept", 32'(last_accept_cyc), 32'(pulse_cyc[1] + 1));
    waitPulses(18, 2500);
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("t3_val%0d", i), 32'(pulse_val[i]), 32'(exp_q[i]));
      if (i > 0) begin
        checkOutput($sformatf("t3_gap%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd100);
      end
    end
    waitIdle(drop_cyc);
    checkOutput("t3_pulse_count", 32'(pulse_val.size()), 32'd18);

    // 4: flush during WAIT
    $display("[TB] flush during wait");
    clearLog();
    applyStimulus(1, 10, 8'h11);
    applyStimulus(5, 10, 8'h21);
    checkOutput("t4_level_5", 32'(fifo_level), 32'd5);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    #1;
    checkOutput("t4_ready_low", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("t4_level_flushed", 32'(fifo_level), 32'd0);
    checkOutput("t4_busy_wait", 32'(busy), 32'd1);
    checkOutput("t4_tx_value_kept", 32'(tx_value), 32'h11);
    waitIdle(drop_cyc);
    checkOutput("t4_drop_time", 32'(drop_cyc - pulse_cyc[0]), 32'd100);
    checkOutput("t4_pulse_count", 32'(pulse_val.size()), 32'd1);
    checkOutput("t4_tx_value_end", 32'(tx_value), 32'h11);

    // 5: asynchronous reset mid-WAIT
    $display("[TB] reset during wait");
    clearLog();
    applyStimulus(1, 10, 8'h33);
    tick();
    repeat (40) tick();
    applyStimulus(2, 10, 8'h77);
    checkOutput("t5_level_2", 32'(fifo_level), 32'd2);
    #2 arst = 1'b1;
    #1;
    checkOutput("t5_tx_value", 32'(tx_value), 32'h0);
    checkOutput("t5_write", 32'(tx_value_write), 32'h0);
    checkOutput("t5_level", 32'(fifo_level), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    tick();
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    checkOutput("t5_no_write_yet", 32'(tx_value_write), 32'd0);
    tick();
    checkOutput("t5_write", 32'(tx_value_write), 32'd1);
    checkOutput("t5_value", 32'(tx_value), 32'h5A);
    waitIdle(drop_cyc);

    // 6: in_valid held for 300 cycles across empty and full
    $display("[TB] sustained valid");
    clearLog();
    applyStimulus(1000, 300, 8'hC0);
    checkOutput("t6_accepted", 32'(accepted), 32'd19);
    checkOutput("t6_max_level", 32'(max_level), 32'd16);
    waitPulses(19, 2500);
    waitIdle(drop_cyc);
    checkOutput("t6_pulse_count", 32'(pulse_val.size()), 32'd19);
    for (int i = 0; i < 19; i++) begin
      checkOutput($sformatf("t6_val%0d", i), 32'(pulse_val[i]), 32'(exp_q[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
